// File: rtl/noise_scan_ctrl.sv
// rtl/noise_scan_ctrl.sv - raster scan of the image buffer through the salt-and-pepper noise rule
// Optional NOISE_BORDER_SKIP_EN: border pixels are emitted unflagged and never counted.
`timescale 1ns/1ps
module noise_scan_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 4,
  parameter int IMG_H      = 2,
  parameter int T1         = 0,
  parameter int T2         = 255,
  parameter int ADDR_W     = $clog2(IMG_W*IMG_H),
  parameter int CNT_W      = $clog2(IMG_W*IMG_H+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_pixel,
  output logic                      out_noise,
  output logic [$clog2(IMG_W)-1:0]  out_x,
  output logic [$clog2(IMG_H)-1:0]  out_y,
  output logic [CNT_W-1:0]          noise_count
);

  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);
  localparam logic [DATA_WIDTH-1:0] LOW_T  = DATA_WIDTH'(T1);
  localparam logic [DATA_WIDTH-1:0] HIGH_T = DATA_WIDTH'(T2);
  localparam logic [X_W-1:0] LAST_X = X_W'(IMG_W-1);
  localparam logic [Y_W-1:0] LAST_Y = Y_W'(IMG_H-1);

  typedef enum logic [2:0] {IDLE, READ, CAPT, EMIT, DONE} stateT;

  stateT state, stateNext;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [DATA_WIDTH-1:0] pixelReg;
  logic noiseReg;
  logic [X_W-1:0] outXReg;
  logic [Y_W-1:0] outYReg;
  logic [CNT_W-1:0] countReg;
  logic lastPixel;
  logic handshake;
  logic thresholdHit;
  logic noiseNext;

  assign lastPixel    = (x == LAST_X) && (y == LAST_Y);
  assign handshake    = (state == EMIT) && out_ready;
  assign thresholdHit = (rd_data <= LOW_T) || (rd_data >= HIGH_T);

`ifdef NOISE_BORDER_SKIP_EN
  // The downstream window cannot be centred on the border, so a flag there would be meaningless.
  logic isBorder;
  assign isBorder  = (x == '0) || (x == LAST_X) || (y == '0) || (y == LAST_Y);
  assign noiseNext = thresholdHit && !isBorder;
`else
  assign noiseNext = thresholdHit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (start) stateNext = READ;
      READ: stateNext = CAPT;
      CAPT: stateNext = EMIT;
      EMIT: if (out_ready) stateNext = lastPixel ? DONE : READ;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    case (state)
      READ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(int'(y) * IMG_W + int'(x));
      end
      CAPT: busy = 1'b1;
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      pixelReg <= '0;
      noiseReg <= 1'b0;
      outXReg  <= '0;
      outYReg  <= '0;
      countReg <= '0;
    end else begin
      if (state == IDLE && start) begin
        x        <= '0;
        y        <= '0;
        countReg <= '0;
      end
      if (state == CAPT) begin
        pixelReg <= rd_data;
        noiseReg <= noiseNext;
        outXReg  <= x;
        outYReg  <= y;
      end
      if (handshake) begin
        if (noiseReg) countReg <= countReg + 1'b1;
        // Position stays on the last pixel after the frame; the next start clears it.
        if (!lastPixel) begin
          if (x == LAST_X) begin
            x <= '0;
            y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
      end
    end
  end

  assign out_pixel   = pixelReg;
  assign out_noise   = noiseReg;
  assign out_x       = outXReg;
  assign out_y       = outYReg;
  assign noise_count = countReg;

endmodule

// File: tb/tb_noise_scan_ctrl.sv
// tb/tb_noise_scan_ctrl.sv - scoreboard bench for noise_scan_ctrl with default and narrowed thresholds
`timescale 1ns/1ps
module tb_noise_scan_ctrl;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  always #5 clk = ~clk;

  logic       busyA, doneA, rdEnA, validA, noiseA;
  logic [2:0] rdAddrA;
  logic [7:0] rdDataA, pixA;
  logic [1:0] xA;
  logic       yA;
  logic [3:0] cntA;

  logic       busyB, doneB, rdEnB, validB, noiseB;
  logic [2:0] rdAddrB;
  logic [7:0] rdDataB, pixB;
  logic [1:0] xB;
  logic       yB;
  logic [3:0] cntB;

  noise_scan_ctrl #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(2), .T1(0), .T2(255)) dutA (
    .clk(clk), .rst(rst), .start(start), .busy(busyA), .done(doneA),
    .rd_en(rdEnA), .rd_addr(rdAddrA), .rd_data(rdDataA),
    .out_valid(validA), .out_ready(out_ready), .out_pixel(pixA), .out_noise(noiseA),
    .out_x(xA), .out_y(yA), .noise_count(cntA));

  noise_scan_ctrl #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(2), .T1(20), .T2(240)) dutB (
    .clk(clk), .rst(rst), .start(start), .busy(busyB), .done(doneB),
    .rd_en(rdEnB), .rd_addr(rdAddrB), .rd_data(rdDataB),
    .out_valid(validB), .out_ready(out_ready), .out_pixel(pixB), .out_noise(noiseB),
    .out_x(xB), .out_y(yB), .noise_count(cntB));

  logic [7:0] mem [8];
  always @(posedge clk) if (rdEnA) rdDataA <= mem[rdAddrA];
  always @(posedge clk) if (rdEnB) rdDataB <= mem[rdAddrB];

  typedef struct packed {
    logic [7:0] pix;
    logic       nz;
    logic [1:0] x;
    logic       y;
  } beatT;

  beatT qA[$];
  beatT qB[$];
  int nChecks = 0;
  int nFails  = 0;
  int rdCntA = 0, rdCntB = 0, doneCntA = 0, doneCntB = 0;
  logic [7:0] flagsA, flagsB;
  int expCntA, expCntB;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  beatT eA, eB;
  always @(negedge clk) begin
    if (rst) begin
      rdCntA = 0;
      qA.delete();
    end else begin
      if (start && !busyA) rdCntA = 0;
      if (rdEnA) begin
        check("rd_addr_A", rdAddrA, rdCntA);
        rdCntA++;
      end
      if (doneA) doneCntA++;
      if (validA) begin
        if (qA.size() == 0) check("unexpected_beat_A", 1, 0);
        else begin
          eA = qA[0];
          check("pixel_A", pixA, eA.pix);
          check("noise_A", noiseA, eA.nz);
          check("x_A", xA, eA.x);
          check("y_A", yA, eA.y);
          if (out_ready) void'(qA.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      rdCntB = 0;
      qB.delete();
    end else begin
      if (start && !busyB) rdCntB = 0;
      if (rdEnB) begin
        check("rd_addr_B", rdAddrB, rdCntB);
        rdCntB++;
      end
      if (doneB) doneCntB++;
      if (validB) begin
        if (qB.size() == 0) check("unexpected_beat_B", 1, 0);
        else begin
          eB = qB[0];
          check("pixel_B", pixB, eB.pix);
          check("noise_B", noiseB, eB.nz);
          check("x_B", xB, eB.x);
          check("y_B", yB, eB.y);
          if (out_ready) void'(qB.pop_front());
        end
      end
    end
  end

  task automatic pushFrame();
    beatT b;
    for (int i = 0; i < 8; i++) begin
      b.pix = mem[i];
      b.x   = 2'(i % 4);
      b.y   = 1'(i / 4);
      b.nz  = flagsA[i];
      qA.push_back(b);
      b.nz  = flagsB[i];
      qB.push_back(b);
    end
  endtask

  task automatic runFrame(input bit stall, input string tag);
    int cycles;
    int stallLeft;
    bit stalled;
    int doneBaseA;
    cycles = 0;
    stallLeft = 0;
    stalled = 0;
    doneBaseA = doneCntA;
    out_ready = 1'b1;
    pushFrame();
    @(posedge clk); #1;
    start = 1'b1;
    while (cycles < 200) begin
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
      if (stall && !stalled && validA && xA == 2'd1 && yA == 1'b0) begin
        out_ready = 1'b0;
        stallLeft = 5;
        stalled = 1;
      end else if (stallLeft > 0) begin
        stallLeft--;
        if (stallLeft == 0) out_ready = 1'b1;
      end
      if (doneA) break;
    end
    if (cycles >= 200) check({tag, "_done_timeout"}, 0, 1);
    if (!stall) check({tag, "_done_latency"}, cycles, 25);
    if (stall) check({tag, "_stall_seen"}, stalled, 1);
    check({tag, "_doneB_same_cycle"}, doneB, 1);
    check({tag, "_busy_in_done"}, busyA, 0);
    check({tag, "_countA"}, cntA, expCntA);
    check({tag, "_countB"}, cntB, expCntB);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, doneA, 0);
    check({tag, "_idle_busy"}, busyA, 0);
    check({tag, "_reads_A"}, rdCntA, 8);
    check({tag, "_reads_B"}, rdCntB, 8);
    check({tag, "_beats_left_A"}, qA.size(), 0);
    check({tag, "_beats_left_B"}, qB.size(), 0);
    check({tag, "_done_pulses"}, doneCntA - doneBaseA, 1);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_count_hold"}, cntA, expCntA);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int doneBase;
    mem[0] = 8'd14;  mem[1] = 8'd0;   mem[2] = 8'd200; mem[3] = 8'd100;
    mem[4] = 8'd255; mem[5] = 8'd0;   mem[6] = 8'd250; mem[7] = 8'd255;
`ifdef NOISE_BORDER_SKIP_EN
    flagsA = 8'b0000_0000;
    flagsB = 8'b0000_0000;
    expCntA = 0;
    expCntB = 0;
`else
    flagsA = 8'b1011_0010;
    flagsB = 8'b1111_0011;
    expCntA = 4;
    expCntB = 6;
`endif
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busyA, 0);
    check("rst_done", doneA, 0);
    check("rst_rd_en", rdEnA, 0);
    check("rst_rd_addr", rdAddrA, 0);
    check("rst_valid", validA, 0);
    check("rst_pixel", pixA, 0);
    check("rst_noise", noiseA, 0);
    check("rst_xy", {xA, yA}, 0);
    check("rst_count", cntA, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_no_reads", rdCntA + rdCntB, 0);
    check("idle_busy", busyA, 0);
    check("idle_valid", validA, 0);

    runFrame(1'b0, "plain");
    runFrame(1'b1, "stall");

    pushFrame();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(validA && xA == 2'd2 && yA == 1'b0) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_third_beat_reached", cyc < 50, 1);
    doneBase = doneCntA;
    rst = 1'b1;
    #1;
    check("abort_busy", busyA, 0);
    check("abort_valid", validA, 0);
    check("abort_count", cntA, 0);
    check("abort_pixel", pixA, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", doneCntA - doneBase, 0);
    runFrame(1'b0, "restart");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/noise_scan_ctrl.md
# noise_scan_ctrl

Raster-scan controller that sequences a stored image through the salt-and-pepper noise detection rule, one centre pixel at a time. It fetches each pixel from a synchronous-read image buffer and classifies it as noisy if it is at or below T1 or at or above T2. It presents pixel, flag and coordinates to the downstream filter stage over a valid/ready handshake, and counts noisy pixels per frame. It sits between the frame buffer and the adaptive filter, and is the only block that drives the detector's centre input.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- IMG_W, 4, image width in pixels (≥2)
- IMG_H, 2, image height in pixels (≥2)
- T1, 0, low noise threshold (inclusive)
- T2, 255, high noise threshold (inclusive)
- ADDR_W, $clog2(IMG_W*IMG_H), buffer address width
- CNT_W, $clog2(IMG_W*IMG_H+1), noise counter width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle frame start request
- busy  out  1  high while a frame scan is in progress
- done  out  1  one-cycle pulse after last pixel accepted
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  buffer address, y*IMG_W+x
- rd_data  in  DATA_WIDTH  buffer data, valid exactly one cycle after rd_en
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_pixel  out  DATA_WIDTH  centre pixel value
- out_noise  out  1  noise flag for out_pixel
- out_x  out  $clog2(IMG_W)  column of out_pixel
- out_y  out  $clog2(IMG_H)  row of out_pixel
- noise_count  out  CNT_W  noisy pixels in current/last frame

## Operation
- FSM states: IDLE, READ, CAPT, EMIT, DONE.
- IDLE: start=1 → clear x, y, noise_count; go to READ. start is ignored in every other state.
- READ: rd_en=1, rd_addr=y*IMG_W+x. Go to CAPT.
- CAPT: register rd_data into out_pixel and x/y into out_x/out_y. out_noise = (rd_data <= T1) || (rd_data >= T2), compared unsigned at DATA_WIDTH. Go to EMIT.
- EMIT: out_valid=1. All out_* are held stable until out_ready=1. On the handshake:
  - noise_count increments if out_noise=1.
  - If x=IMG_W-1 and y=IMG_H-1, go to DONE.
  - Otherwise advance x; on column wrap, x=0 and y increments. Go to READ.
- DONE: done=1 for one cycle. Go to IDLE.
- busy=1 in READ, CAPT and EMIT. It is 0 in IDLE and DONE.
- noise_count holds its final value after DONE until the next accepted start.
- Counter cannot overflow: CNT_W covers IMG_W*IMG_H.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_pixel=0, out_noise=0, out_x=0, out_y=0, noise_count=0. State is IDLE, x=y=0.
- start sampled in cycle N → READ (rd_en=1) in N+1. CAPT in N+2. out_valid=1 from N+3.
- Per-pixel minimum is 3 cycles with out_ready held high. Minimum frame length is 3*IMG_W*IMG_H+1 cycles from start to done (inclusive of the DONE cycle).
- rd_en is a single-cycle pulse per pixel. rd_addr is stable in the READ cycle. rd_en is never asserted outside READ.
- out_valid never drops without a handshake. Backpressure of any length is tolerated.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously). The frame is abandoned, and no done pulse is issued.
- start coincident with done/DONE is ignored; start is only accepted in IDLE.

## Configuration
- NOISE_BORDER_SKIP_EN defined:
  - Pixels with x=0, x=IMG_W-1, y=0 or y=IMG_H-1 are still fetched and emitted.
  - Their out_noise is forced to 0, and they are never counted. The filter window cannot be centred there.
- Not defined: every pixel is classified by the threshold rule, including the borders.

## Test plan
- Reset then idle: hold rst 3 cycles, no start → all outputs 0, rd_en never high.
- 4x2 frame {14,0,200,100,255,0,250,255}, T1=0, T2=255, out_ready=1, macro off:
  - Flags are 0,1,0,0,1,1,0,1.
  - noise_count=4.
  - done exactly 25 cycles after the start cycle.
- Same frame, out_ready low for 5 cycles on beat (x=1, y=0):
  - out_pixel=0, out_noise=1 and out_x/out_y held throughout the stall.
  - No second rd_en during the stall; final count 4.
- T1=20, T2=240, same frame → flags 1,1,0,0,1,1,1,1; noise_count=6.
- NOISE_BORDER_SKIP_EN on, 4x2 frame (all border) → all out_noise=0, noise_count=0, 8 beats emitted.
- Reset at 3rd beat, then start again:
  - busy drops immediately and no done is issued for the aborted frame.
  - The new frame completes with noise_count=4.
